// File: rtl/tf_stage_sequencer.sv
// rtl/tf_stage_sequencer.sv - twiddle-factor BRAM read sequencer for a multi-stage FFT frame
// Issues 2^bram_tf_addr_len strided reads per stage, with drain gaps between stages.
module tf_stage_sequencer #(
  parameter int stage_num        = 12,
  parameter int bram_tf_addr_len = 11,
  parameter int gap_cyc          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        stall,
  output logic                        tf_en,
  output logic [bram_tf_addr_len-1:0] tf_addr,
  output logic                        tf_valid,
  output logic [3:0]                  tf_stage,
  output logic                        busy,
  output logic                        done
);

  localparam int gw = (gap_cyc < 2) ? 1 : $clog2(gap_cyc);

  localparam logic [gw-1:0]               gap_last   = gw'(gap_cyc - 1);
  localparam logic [gw-1:0]               gap_one    = gw'(1);
  localparam logic [3:0]                  stage_last = 4'(stage_num - 1);
  localparam logic [bram_tf_addr_len-1:0] k_last     = '1;
  localparam logic [bram_tf_addr_len-1:0] k_one      = bram_tf_addr_len'(1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, LAST} state_t;

  state_t                        state, state_n;
  logic [bram_tf_addr_len-1:0]   k, k_n, addr_n;
  logic [3:0]                    stage, stage_n;
  logic [gw-1:0]                 gcnt, gcnt_n;
  logic                          en_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      stage    <= '0;
      gcnt     <= '0;
      tf_en    <= 1'b0;
      tf_addr  <= '0;
      tf_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      stage    <= stage_n;
      gcnt     <= gcnt_n;
      tf_en    <= en_n;
      tf_addr  <= addr_n;
      tf_valid <= tf_en;
      // Lines up with tf_valid of the final read; an abort in LAST suppresses it.
      done     <= (state == LAST) && !abort;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    stage_n = stage;
    gcnt_n  = gcnt;
    en_n    = 1'b0;
    addr_n  = tf_addr;
    if (abort) begin
      state_n = IDLE;
      gcnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = RUN;
            k_n     = '0;
            stage_n = '0;
            gcnt_n  = '0;
          end
        end
        RUN: begin
          if (!stall) begin
            en_n   = 1'b1;
            // Stride doubles each stage; bits shifted past the address width drop out.
            addr_n = k << stage;
            k_n    = k + k_one;
            if (k == k_last) begin
              state_n = (stage == stage_last) ? LAST : GAP;
            end
          end
        end
        GAP: begin
          if (gcnt == gap_last) begin
            gcnt_n  = '0;
            stage_n = stage + 4'd1;
            state_n = RUN;
          end else begin
            gcnt_n = gcnt + gap_one;
          end
        end
        LAST: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign tf_stage = stage;

endmodule

// File: tb/tb_tf_stage_sequencer.sv
// tb/tb_tf_stage_sequencer.sv - scoreboard bench for tf_stage_sequencer
// Small-parameter instance for directed/random frames, default instance for back-to-back frames.
module tb_tf_stage_sequencer;
  localparam int SN    = 3;
  localparam int AW    = 3;
  localparam int GC    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = SN * DEPTH + (SN - 1) * GC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0, stall = 1'b0;
  logic tf_en, tf_valid, busy, done;
  logic [AW-1:0] tf_addr;
  logic [3:0] tf_stage;

  logic d_rst = 1'b1, d_start = 1'b0, d_abort = 1'b0, d_stall = 1'b0;
  logic d_en, d_valid, d_busy, d_done;
  logic [10:0] d_addr;
  logic [3:0] d_stage;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  bit prev_en = 1'b0;

  typedef struct {
    int stage;
    int addr;
  } rd_t;
  rd_t expq[$];
  rd_t mon_e;

  always #5 clk = ~clk;

  tf_stage_sequencer #(.stage_num(SN), .bram_tf_addr_len(AW), .gap_cyc(GC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
    .tf_en(tf_en), .tf_addr(tf_addr), .tf_valid(tf_valid), .tf_stage(tf_stage),
    .busy(busy), .done(done)
  );

  tf_stage_sequencer dut_def (
    .clk(clk), .rst(d_rst), .start(d_start), .abort(d_abort), .stall(d_stall),
    .tf_en(d_en), .tf_addr(d_addr), .tf_valid(d_valid), .tf_stage(d_stage),
    .busy(d_busy), .done(d_done)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: stage s reads k*2^s modulo the BRAM depth, k = 0..DEPTH-1.
  task automatic push_frame();
    rd_t r;
    for (int s = 0; s < SN; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        r.stage = s;
        r.addr  = (k << s) % DEPTH;
        expq.push_back(r);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      check("tf_valid_follows_en", int'(tf_valid), int'(prev_en));
      prev_en = tf_en;
      if (tf_en) begin
        en_cnt++;
        if (expq.size() == 0) begin
          check("unexpected_read", int'(tf_addr), -1);
        end else begin
          mon_e = expq.pop_front();
          check("tf_addr", int'(tf_addr), mon_e.addr);
          check("tf_stage", int'(tf_stage), mon_e.stage);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0 plain, 1 directed stall, 2 random stall, 3 abort in stage1 gap, 4 restart attempts
  task automatic run_frame(input int mode, output int lat);
    int n, hold, s1;
    bit fired, quit;
    n = 0; hold = 0; s1 = 0; fired = 1'b0; quit = 1'b0;
    push_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    while (!done && !quit && n < 3000) begin
      case (mode)
        1: begin
          if (hold > 0) begin
            hold--;
            if (hold == 0) stall = 1'b0;
          end else if (!fired && tf_en && tf_stage == 4'd1 && tf_addr == 3'd4) begin
            stall = 1'b1; hold = 3; fired = 1'b1;
          end
        end
        2: stall = ($urandom_range(0, 3) == 0);
        3: begin
          if (tf_en && tf_stage == 4'd1) s1++;
          if (fired) begin
            abort = 1'b0;
            check("busy_after_abort", int'(busy), 0);
            quit = 1'b1;
          end else if (s1 == DEPTH) begin
            abort = 1'b1; fired = 1'b1;
          end
        end
        4: start = (n == 10 || n == 20);
        default: ;
      endcase
      if (!quit) begin
        @(negedge clk);
        n++;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    if (!quit) check("frame_done_seen", int'(done), 1);
    lat = n;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, e0, d0, n, frames, fcnt, last_done;
    bit gap_checked;

    #1;
    check("rst_tf_en", int'(tf_en), 0);
    check("rst_tf_addr", int'(tf_addr), 0);
    check("rst_tf_valid", int'(tf_valid), 0);
    check("rst_tf_stage", int'(tf_stage), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    idle_wait(2);
    rst = 1'b0;
    idle_wait(2);

    e0 = en_cnt; d0 = done_cnt;
    run_frame(0, lat);
    check("latency_no_stall", lat, LAT);
    idle_wait(5);
    check("en_cycles_frame", en_cnt - e0, SN * DEPTH);
    check("done_pulses_frame", done_cnt - d0, 1);
    check("queue_drained", expq.size(), 0);

    e0 = en_cnt; d0 = done_cnt;
    run_frame(1, lat);
    check("latency_with_stall", lat, LAT + 3);
    idle_wait(5);
    check("en_cycles_stall", en_cnt - e0, SN * DEPTH);
    check("queue_drained_stall", expq.size(), 0);

    e0 = en_cnt; d0 = done_cnt;
    run_frame(3, lat);
    check("reads_left_after_abort", expq.size(), DEPTH);
    expq.delete();
    idle_wait(40);
    check("busy_idle_after_abort", int'(busy), 0);
    check("no_done_after_abort", done_cnt - d0, 0);
    check("en_cycles_before_abort", en_cnt - e0, 2 * DEPTH);
    d0 = done_cnt;
    run_frame(0, lat);
    check("latency_after_abort", lat, LAT);
    idle_wait(5);
    check("done_after_restart", done_cnt - d0, 1);

    e0 = en_cnt; d0 = done_cnt;
    run_frame(4, lat);
    check("latency_restart_ignored", lat, LAT);
    idle_wait(5);
    check("en_cycles_restart_ignored", en_cnt - e0, SN * DEPTH);
    check("done_restart_ignored", done_cnt - d0, 1);
    check("queue_drained_restart", expq.size(), 0);

    e0 = en_cnt;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("idle_start_abort", int'(busy), 0);
      @(negedge clk);
    end
    check("idle_start_abort_en", en_cnt - e0, 0);

    for (int f = 0; f < 3; f++) begin
      e0 = en_cnt; d0 = done_cnt;
      run_frame(2, lat);
      idle_wait(5);
      check("rand_en_cycles", en_cnt - e0, SN * DEPTH);
      check("rand_done", done_cnt - d0, 1);
      check("rand_queue_drained", expq.size(), 0);
    end

    d0 = done_cnt;
    push_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    idle_wait(5);
    #2 rst = 1'b1;
    #1;
    check("arst_tf_en", int'(tf_en), 0);
    check("arst_tf_addr", int'(tf_addr), 0);
    check("arst_tf_valid", int'(tf_valid), 0);
    check("arst_tf_stage", int'(tf_stage), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    expq.delete();
    idle_wait(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_tf_valid", int'(tf_valid), 0);
      check("post_rst_busy", int'(busy), 0);
    end
    check("post_rst_no_done", done_cnt - d0, 0);

    @(negedge clk);
    d_rst = 1'b0;
    @(negedge clk);
    d_start = 1'b1;
    n = 0; frames = 0; fcnt = 0; last_done = -1; gap_checked = 1'b0;
    while (frames < 2 && n < 60000) begin
      @(negedge clk);
      n++;
      if (d_en) begin
        fcnt++;
        if (last_done >= 0 && !gap_checked) begin
          check("b2b_restart_gap", n - last_done, 2);
          gap_checked = 1'b1;
        end
      end
      if (d_done) begin
        frames++;
        check("b2b_en_per_frame", fcnt, 12 * 2048);
        if (frames == 1) check("b2b_latency", n, 12 * 2048 + 11 * 4 + 2);
        fcnt = 0;
        last_done = n;
      end
    end
    check("b2b_frames", frames, 2);
    d_start = 1'b0;
    d_rst = 1'b1;
    idle_wait(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tf_stage_sequencer.md
TF_STAGE_SEQUENCER -- requirements
Module: tf_stage_sequencer

Interface
REQ-001: Parameter stage_num, default 12, meaning number of FFT stages sequenced per frame (1..16).
REQ-002: Parameter bram_tf_addr_len, default 11, meaning twiddle BRAM address width; reads per stage = 2^bram_tf_addr_len.
REQ-003: Parameter gap_cyc, default 4, meaning idle cycles inserted between stages for pipeline drain (>=1).
REQ-004: clk  input  1  system clock, all state on rising edge.
REQ-005: rst  input  1  reset, asynchronous, active-high.
REQ-006: start  input  1  frame start request, sampled in IDLE only.
REQ-007: abort  input  1  synchronous cancel of the current frame.
REQ-008: stall  input  1  downstream back-pressure; freezes read issue while high.
REQ-009: tf_en  output  1  twiddle BRAM read enable, registered.
REQ-010: tf_addr  output  bram_tf_addr_len  twiddle BRAM address, registered.
REQ-011: tf_valid  output  1  twiddle data valid at BRAM output; tf_en delayed 1 cycle.
REQ-012: tf_stage  output  4  index of stage currently issued (0..stage_num-1).
REQ-013: busy  output  1  high in every state except IDLE.
REQ-014: done  output  1  single-cycle frame-complete pulse.

Function
REQ-015: The block SHALL implement FSM states IDLE, RUN, GAP, LAST.
REQ-016: IDLE -> RUN on start=1 and abort=0; k (read counter) and stage SHALL be cleared to 0 on this transition.
REQ-017: In RUN with stall=0, each edge SHALL set tf_en<=1, tf_addr<=(k<<stage) truncated to bram_tf_addr_len bits (shift >= width gives 0), and increment k.
REQ-018: In RUN with stall=1, tf_en SHALL be 0 and k, stage, tf_addr SHALL hold.
REQ-019: When k=2^bram_tf_addr_len-1 issues and stage<stage_num-1: k wraps to 0, FSM -> GAP.
REQ-020: When k=2^bram_tf_addr_len-1 issues and stage=stage_num-1: FSM -> LAST.
REQ-021: GAP SHALL last exactly gap_cyc cycles regardless of stall, tf_en=0; on exit stage increments and FSM -> RUN.
REQ-022: LAST SHALL last one cycle with tf_en<=0, then FSM -> IDLE; done SHALL be registered from state==LAST, so done coincides with tf_valid of the final read.
REQ-023: tf_valid SHALL equal tf_en of the previous cycle in all states, including after abort.
REQ-024: tf_stage SHALL equal stage register; busy SHALL be combinational from state.
REQ-025: start while busy=1 SHALL be ignored (no restart, no queuing).
REQ-026: abort=1 in any state SHALL force IDLE on the next edge, tf_en<=0, done not asserted; abort wins over simultaneous start.
REQ-027: Total tf_en-high cycles per uninterrupted frame SHALL be stage_num*2^bram_tf_addr_len.
REQ-028: Duration start-to-done with no stall SHALL be stage_num*2^bram_tf_addr_len + (stage_num-1)*gap_cyc + 2 cycles.

Reset
REQ-029: rst=1 SHALL immediately force state=IDLE, k=0, stage=0, gap counter=0, tf_en=0, tf_addr=0, tf_valid=0, tf_stage=0, done=0, busy=0.
REQ-030: rst asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a new start.

Verification (bench params stage_num=3, bram_tf_addr_len=3, gap_cyc=2)
REQ-031: Single start, no stall -> tf_addr sequence stage0 0..7, stage1 0,2,4,6,0,2,4,6, stage2 0,4,0,4,0,4,0,4; 24 tf_en cycles; two 2-cycle gaps; done one pulse 30 cycles after start.
REQ-032: stall=1 for 3 cycles at stage1 k=3 -> tf_en low 3 cycles, next address 6 (no skip/repeat), done delayed by 3 cycles.
REQ-033: abort during stage1 GAP -> busy low next cycle, no further tf_en, no done; new start then runs full frame from stage0 addr 0.
REQ-034: start pulsed again mid-frame and start+abort together in IDLE -> both ignored, frame count and addresses unchanged, block stays IDLE for the latter.
REQ-035: rst asserted asynchronously mid-RUN (between edges) -> all outputs 0 immediately; tf_valid does not pulse after release.
REQ-036: Default params, back-to-back frames (start held high) -> each frame exactly 24576 tf_en cycles, one done per frame, new frame starts the cycle after done's IDLE.
